// File: rtl/depth_slicer.sv
// depth_slicer: tags each depth pixel of a frame with a layer index (how many
// of the frame's thresholds it reaches) plus end-of-line / end-of-frame marks.
//
// Handshakes (all three ports): a transfer happens on a rising clock edge where
// valid and ready are both high. A source holds valid and its payload stable
// until the transfer. pix_in_ready depends combinationally on pix_out_ready, so
// a pixel can stream through at one per clock without a skid buffer.
module depth_slicer #(
  parameter int p_depth_bit  = 8,
  parameter int p_width_bit  = 11,
  parameter int p_height_bit = 11,
  parameter int p_th_num     = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [p_width_bit-1:0]                width,
  input  logic [p_height_bit-1:0]               height,
  input  logic                                  frame_start,
  input  logic                                  th_valid,
  output logic                                  th_ready,
  input  logic [p_th_num-1:0][p_depth_bit-1:0]  th,
  input  logic                                  pix_in_valid,
  output logic                                  pix_in_ready,
  input  logic [p_depth_bit-1:0]                pix_in_depth,
  output logic                                  pix_out_valid,
  input  logic                                  pix_out_ready,
  output logic [p_depth_bit-1:0]                pix_out_depth,
  output logic [$clog2(p_th_num+1)-1:0]         pix_out_layer,
  output logic                                  pix_out_eol,
  output logic                                  pix_out_eof,
  output logic                                  frame_done,
  output logic [1:0]                            dbg_state
);

  localparam int p_layer_bit = $clog2(p_th_num + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_TH = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  localparam logic [p_width_bit-1:0]  one_x     = 1;
  localparam logic [p_height_bit-1:0] one_y     = 1;
  localparam logic [p_layer_bit-1:0]  one_layer = 1;

  logic [1:0]                           state;
  logic [p_width_bit-1:0]               width_q;
  logic [p_height_bit-1:0]              height_q;
  logic [p_width_bit-1:0]               x_q;
  logic [p_height_bit-1:0]              y_q;
  logic [p_th_num-1:0][p_depth_bit-1:0] th_q;

  logic                   start_ok;
  logic                   th_xfer;
  logic                   in_xfer;
  logic                   out_xfer;
  logic                   x_last;
  logic                   y_last;
  logic [p_layer_bit-1:0] layer_next;

  assign dbg_state    = state;
  assign th_ready     = (state == ST_WAIT_TH);
  assign pix_in_ready = (state == ST_RUN) && (!pix_out_valid || pix_out_ready);

  assign start_ok = (state == ST_IDLE) && frame_start && (width != '0) && (height != '0);
  assign th_xfer  = th_valid && th_ready;
  assign in_xfer  = pix_in_valid && pix_in_ready;
  assign out_xfer = pix_out_valid && pix_out_ready;
  assign x_last   = (x_q == width_q - one_x);
  assign y_last   = (y_q == height_q - one_y);

  // Layer index is a popcount of reached thresholds, so their order is irrelevant.
  always_comb begin
    layer_next = '0;
    for (int i = 0; i < p_th_num; i++) begin
      if (pix_in_depth >= th_q[i]) layer_next = layer_next + one_layer;
    end
  end

  // Frame control FSM; frame_done pulses as the eof pixel leaves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE:    if (start_ok) state <= ST_WAIT_TH;
        ST_WAIT_TH: if (th_xfer) state <= ST_RUN;
        ST_RUN:     if (in_xfer && x_last && y_last) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (out_xfer) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Frame geometry, threshold set and raster position.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      width_q  <= '0;
      height_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      th_q     <= '0;
    end else begin
      if (start_ok) begin
        width_q  <= width;
        height_q <= height;
        x_q      <= '0;
        y_q      <= '0;
      end
      if (th_xfer) th_q <= th;
      if (in_xfer) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + one_y;
        end else begin
          x_q <= x_q + one_x;
        end
      end
    end
  end

  // Output register: loads on each accepted pixel, holds while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_out_valid <= 1'b0;
      pix_out_depth <= '0;
      pix_out_layer <= '0;
      pix_out_eol   <= 1'b0;
      pix_out_eof   <= 1'b0;
    end else if (in_xfer) begin
      pix_out_valid <= 1'b1;
      pix_out_depth <= pix_in_depth;
      pix_out_layer <= layer_next;
      pix_out_eol   <= x_last;
      pix_out_eof   <= x_last && y_last;
    end else if (out_xfer) begin
      pix_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_depth_slicer.sv
// Bench for depth_slicer: drives frames through the threshold and pixel
// handshakes, predicts each tagged pixel with an independent popcount model.
module tb_depth_slicer;

  localparam int DB = 8;
  localparam int WB = 11;
  localparam int HB = 11;
  localparam int TN = 4;
  localparam int LB = 3;
  localparam int W  = DB + LB + 2;

  logic                   clk;
  logic                   rstn;
  logic [WB-1:0]          width;
  logic [HB-1:0]          height;
  logic                   frame_start;
  logic                   th_valid;
  logic                   th_ready;
  logic [TN-1:0][DB-1:0]  th;
  logic                   pix_in_valid;
  logic                   pix_in_ready;
  logic [DB-1:0]          pix_in_depth;
  logic                   pix_out_valid;
  logic                   pix_out_ready;
  logic [DB-1:0]          pix_out_depth;
  logic [LB-1:0]          pix_out_layer;
  logic                   pix_out_eol;
  logic                   pix_out_eof;
  logic                   frame_done;
  logic [1:0]             dbg_state;

  depth_slicer #(
    .p_depth_bit(DB), .p_width_bit(WB), .p_height_bit(HB), .p_th_num(TN)
  ) dut (
    .clk(clk), .rstn(rstn), .width(width), .height(height),
    .frame_start(frame_start), .th_valid(th_valid), .th_ready(th_ready), .th(th),
    .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready), .pix_in_depth(pix_in_depth),
    .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready),
    .pix_out_depth(pix_out_depth), .pix_out_layer(pix_out_layer),
    .pix_out_eol(pix_out_eol), .pix_out_eof(pix_out_eof),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]          exp_q[$];
  logic [DB-1:0]         pix_src[$];
  logic [TN-1:0][DB-1:0] th_cur;
  int mx, my, cur_w, cur_h;
  bit bp_mode;
  int exp_done = 0;
  int done_seen = 0;
  int done_stage = 0;
  bit stall_prev;
  logic [W-1:0] stall_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LB-1:0] model_layer(input logic [DB-1:0] d,
                                                input logic [TN-1:0][DB-1:0] t);
    int n = 0;
    for (int i = 0; i < TN; i++) if (d >= t[i]) n++;
    return LB'(n);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic start_frame(input int w, input int h);
    width = WB'(w);
    height = HB'(h);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    if (w != 0 && h != 0) begin
      cur_w = w; cur_h = h; mx = 0; my = 0;
    end
  endtask

  task automatic load_th(input logic [TN-1:0][DB-1:0] t);
    int n = 0;
    th = t;
    th_valid = 1'b1;
    chk("th_ready_first", 32'(th_ready), 1);
    chk("pix_in_ready_wait_th", 32'(pix_in_ready), 0);
    chk("state_wait_th", 32'(dbg_state), 1);
    while (!th_ready && n < 50) begin cyc(); n++; end
    if (!th_ready) chk("th_ready_timeout", 0, 1);
    th_cur = t;
    cyc();
    th_valid = 1'b0;
  endtask

  task automatic send_pixels(input int n);
    logic [DB-1:0] d;
    logic eol, eof;
    int t;
    for (int k = 0; k < n; k++) begin
      d = pix_src.pop_front();
      pix_in_valid = 1'b1;
      pix_in_depth = d;
      t = 0;
      @(negedge clk);
      while (!pix_in_ready && t < 200) begin @(negedge clk); t++; end
      if (!pix_in_ready) begin
        chk("pix_in_ready_timeout", 0, 1);
      end else begin
        eol = (mx == cur_w - 1);
        eof = eol && (my == cur_h - 1);
        exp_q.push_back({d, model_layer(d, th_cur), eol, eof});
        if (eol) begin mx = 0; my++; end else mx++;
      end
      @(posedge clk);
      #1;
    end
    pix_in_valid = 1'b0;
  endtask

  // returns at the negedge of the frame_done cycle
  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!frame_done && t < 200) begin @(negedge clk); t++; end
    chk("frame_done_reached", 32'(frame_done), 1);
    chk("idle_at_done", 32'(dbg_state), 0);
    exp_done++;
  endtask

  task automatic run_frame(input int w, input int h, input logic [TN-1:0][DB-1:0] t);
    start_frame(w, h);
    load_th(t);
    send_pixels(w * h);
    wait_done();
  endtask

  // downstream ready: always 1, or a 1,0,0,1 pattern in backpressure mode
  initial begin
    int idx = 0;
    pix_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        pix_out_ready = (idx == 0 || idx == 3);
        idx = (idx + 1) % 4;
      end else begin
        pix_out_ready = 1'b1;
      end
    end
  end

  // scoreboard / monitor
  initial begin
    logic [W-1:0] cur, e;
    forever begin
      @(negedge clk);
      cur = {pix_out_depth, pix_out_layer, pix_out_eol, pix_out_eof};
      if (!rstn) begin
        stall_prev = 1'b0;
        done_stage = 0;
      end else begin
        if (frame_done) done_seen++;
        if (done_stage == 1) begin
          chk("frame_done_pulse", 32'(frame_done), 1);
          done_stage = 2;
        end else if (done_stage == 2) begin
          chk("frame_done_one_cycle", 32'(frame_done), 0);
          done_stage = 0;
        end
        if (stall_prev) begin
          chk("stall_valid_held", 32'(pix_out_valid), 1);
          chk("stall_data_held", 32'(cur), 32'(stall_val));
        end
        if (pix_out_valid && !pix_out_ready) chk("pix_in_ready_stalled", 32'(pix_in_ready), 0);
        if (pix_out_valid && pix_out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 32'(cur), 0);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", 32'(cur), 32'(e));
            if (pix_out_eof) done_stage = 1;
          end
        end
        stall_prev = pix_out_valid && !pix_out_ready;
        stall_val = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=0 exp=1");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TN-1:0][DB-1:0] th_a;
    logic [TN-1:0][DB-1:0] th_b;
    logic [DB-1:0] basic_d[8];
    basic_d = '{8'd0, 8'd10, 8'd25, 8'd40, 8'd255, 8'd19, 8'd30, 8'd39};
    th_a = {8'd40, 8'd30, 8'd20, 8'd10};

    rstn = 1'b0; width = '0; height = '0; frame_start = 1'b0;
    th_valid = 1'b0; th = '0; pix_in_valid = 1'b0; pix_in_depth = '0;
    bp_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 0);
    chk("rst_th_ready", 32'(th_ready), 0);
    chk("rst_pix_in_ready", 32'(pix_in_ready), 0);
    chk("rst_out_valid", 32'(pix_out_valid), 0);
    chk("rst_out_data", 32'({pix_out_depth, pix_out_layer, pix_out_eol, pix_out_eof}), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    rstn = 1'b1;
    cyc();

    // handshake gating in IDLE
    th_valid = 1'b1; th = th_a; pix_in_valid = 1'b1; pix_in_depth = 8'd7;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_th_ready", 32'(th_ready), 0);
      chk("idle_pix_in_ready", 32'(pix_in_ready), 0);
    end
    // zero-dimension frame_start is ignored
    start_frame(0, 3);
    chk("zero_w_state", 32'(dbg_state), 0);
    chk("zero_w_th_ready", 32'(th_ready), 0);
    start_frame(5, 0);
    chk("zero_h_state", 32'(dbg_state), 0);
    th_valid = 1'b0; pix_in_valid = 1'b0;
    cyc();

    // basic frame
    for (int i = 0; i < 8; i++) pix_src.push_back(basic_d[i]);
    run_frame(4, 2, th_a);
    cyc();

    // same frame with backpressure
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) pix_src.push_back(basic_d[i]);
    run_frame(4, 2, th_a);
    cyc();

    // 1x1 frame, depth equals th[0]
    pix_src.push_back(8'd5);
    run_frame(1, 1, {8'd200, 8'd200, 8'd200, 8'd5});
    cyc();

    // reset mid-frame after 3 of 8 pixels
    bp_mode = 1'b0;
    for (int i = 0; i < 8; i++) pix_src.push_back(basic_d[i]);
    start_frame(4, 2);
    load_th(th_a);
    send_pixels(3);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(pix_out_valid), 0);
    chk("mid_rst_data", 32'({pix_out_depth, pix_out_layer, pix_out_eol, pix_out_eof}), 0);
    chk("mid_rst_th_ready", 32'(th_ready), 0);
    chk("mid_rst_pix_in_ready", 32'(pix_in_ready), 0);
    chk("mid_rst_state", 32'(dbg_state), 0);
    chk("mid_rst_frame_done", 32'(frame_done), 0);
    pix_src.delete();
    exp_q.delete();
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) pix_src.push_back(DB'($urandom_range(0, 255)));
    run_frame(4, 2, {8'd220, 8'd60, 8'd150, 8'd90});
    cyc();

    // back-to-back: second frame_start lands in the frame_done cycle
    bp_mode = 1'b0;
    for (int i = 0; i < 6; i++) pix_src.push_back(DB'($urandom_range(0, 255)));
    run_frame(3, 2, th_a);
    th_b = '0;
    for (int i = 0; i < 10; i++) pix_src.push_back(DB'($urandom_range(0, 255)));
    run_frame(5, 2, th_b);
    cyc();
    cyc();

    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("frame_done_count", 32'(done_seen), 32'(exp_done));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/depth_slicer.md
# depth_slicer

Downstream consumer of the histogram threshold stage. Once per frame it latches the `p_th_num` depth thresholds from the threshold XDS output, then streams that frame's depth pixels. Each pixel is tagged with a layer index (0..p_th_num) and with end-of-line / end-of-frame markers for the segmentation stages further down.

## Interface
- p_depth_bit, 8, depth sample width
- p_width_bit, 11, frame width field width
- p_height_bit, 11, frame height field width
- p_th_num, 4, number of thresholds; p_layer_bit = $clog2(p_th_num+1) is derived, not overridable
- clk  in  1  clock, all logic rising-edge
- rstn  in  1  asynchronous active-low reset
- width  in  p_width_bit  frame width in pixels, sampled on frame_start
- height  in  p_height_bit  frame height in lines, sampled on frame_start
- frame_start  in  1  one-cycle pulse, arms a new frame
- th_valid  in  1  threshold set valid (from histogram stage xds_out_valid)
- th_ready  out  1  threshold set accepted
- th  in  p_depth_bit x p_th_num  threshold array (histo_th)
- pix_in_valid  in  1  depth pixel valid
- pix_in_ready  out  1  depth pixel accepted
- pix_in_depth  in  p_depth_bit  depth sample
- pix_out_valid  out  1  tagged pixel valid
- pix_out_ready  in  1  downstream accepts
- pix_out_depth  out  p_depth_bit  depth, passed through
- pix_out_layer  out  p_layer_bit  layer index
- pix_out_eol  out  1  last pixel of line
- pix_out_eof  out  1  last pixel of frame
- frame_done  out  1  one-cycle pulse after eof pixel transfers

## Operation
- Input transfer: pix_in_valid & pix_in_ready. Output transfer: pix_out_valid & pix_out_ready. Threshold transfer: th_valid & th_ready.
- FSM states: IDLE, WAIT_TH, RUN, DRAIN.
- IDLE: on frame_start with width!=0 and height!=0, latch width/height, clear x/y counters, go to WAIT_TH. frame_start with a zero dimension is ignored; stay in IDLE.
- WAIT_TH: th_ready=1. On a threshold transfer, latch all p_th_num thresholds and go to RUN.
- RUN: pix_in_ready = !pix_out_valid | pix_out_ready. th_ready=0.
- Each accepted pixel loads the output register:
  - layer = number of i with depth >= th[i]. This is a popcount, so threshold order is irrelevant.
  - eol = (x == width-1).
  - eof = eol & (y == height-1).
- Counters: x increments per accepted pixel and wraps to 0 at width-1, at which point y increments.
- On accepting the eof pixel, go to DRAIN with pix_in_ready=0.
- DRAIN: when the eof pixel transfers, pulse frame_done and go to IDLE.
- frame_start outside IDLE is ignored. th_valid outside WAIT_TH is not acknowledged.
- Threshold equal to depth counts as reached. With all thresholds at 0, every pixel gets layer = p_th_num.

## Timing
- Reset values:
  - State = IDLE.
  - th_ready, pix_in_ready, pix_out_valid, pix_out_eol, pix_out_eof, frame_done = 0.
  - pix_out_depth, pix_out_layer = 0.
  - Latched thresholds, width, height, x, y = 0.
- Reset asserted mid-frame clears all of the above immediately. The partial frame is discarded with no frame_done.
- frame_start → WAIT_TH on the next edge. th_ready is high in the first WAIT_TH cycle.
- Threshold transfer → RUN on the next edge. pix_in_ready can be high in that cycle.
- Latency: 1 cycle, accepted pixel to pix_out_valid.
- Throughput: 1 pixel/clk while pix_out_ready=1. A skid buffer is not needed because ready passes through combinationally.
- Output stability: pix_out_* holds stable while pix_out_valid & !pix_out_ready.
- frame_done asserts the cycle after the eof output transfer, for exactly 1 cycle. The block is back in IDLE in that same cycle, so a frame_start coincident with frame_done is accepted.
- Frame of 1x1: the single pixel carries eol=eof=1.

## Test plan
- Basic frame:
  - Stimulus: width=4, height=2, th={10,20,30,40}; depths 0,10,25,40,255,19,30,39 with pix_out_ready=1.
  - Required: layers 0,1,2,4,4,1,3,3; eol on pixels 3 and 7; eof on pixel 7; frame_done 1 cycle after.
- Backpressure:
  - Stimulus: same frame, with pix_out_ready toggling 1,0,0,1 repeatedly.
  - Required: no pixel lost or duplicated; outputs stable while stalled; pix_in_ready=0 during stalls.
- Handshake gating:
  - Stimulus: th_valid held high in IDLE; pixels offered before the thresholds are accepted.
  - Required: th_ready=0 until after frame_start; pix_in_ready=0 until RUN.
- Degenerate sizes:
  - Stimulus: frame_start with width=0 → ignored, state stays IDLE. Then a 1x1 frame with depth=th[0]=5, other thresholds 200.
  - Required: the 1x1 pixel gets layer=1, eol=eof=1.
- Reset mid-frame:
  - Stimulus: assert rstn=0 after 3 of 8 pixels.
  - Required: all outputs 0 asynchronously; no frame_done. After release, a new full frame completes correctly.
- Back-to-back frames:
  - Stimulus: frame_start issued in the frame_done cycle, then new thresholds.
  - Required: second frame is tagged with the new thresholds; x/y restart at 0.
